// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised RxD, majority-voted mid-bit sampling,
// parity/stop checking and a ready/valid output with per-frame error flags.
module uart_rx_os #(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RxD,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  rx_idle
);
    localparam int DIV   = CLKFREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0]  SC_S0     = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_S1     = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  SC_S2     = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_WIDTH - 1);
    localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] d, input logic p);
        logic x;
        x = ^{d, p};
        case (PARITY)
            1:       parity_fail = ~x;
            2:       parity_fail = x;
            default: parity_fail = 1'b0;
        endcase
    endfunction

    state_t                  state_r, state_n;
    logic [1:0]              sync_r;
    logic                    rxs_prev_r;
    logic [DIV_W-1:0]        div_r;
    logic [SC_W-1:0]         sc_r;
    logic [BC_W-1:0]         bc_r;
    logic [1:0]              samp_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    perr_r;
    logic                    stop_err_r;
    logic                    all_zero_r;

    logic rxs_s, fall_s, tick_s, bit_done_s, maj_s;
    logic start_s, frame_done_s, fe_s, brk_s;

    assign rxs_s  = sync_r[1];
    assign fall_s = rxs_prev_r & ~rxs_s;
    assign tick_s = (div_r == DIV_LAST);

    // Two-flop synchroniser plus the previous-sample flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r     <= 2'b11;
            rxs_prev_r <= 1'b1;
        end else begin
            sync_r     <= {sync_r[0], RxD};
            rxs_prev_r <= sync_r[1];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode; a bit resolves on the third of the three mid-bit samples
    always_comb begin
        state_n      = state_r;
        start_s      = 1'b0;
        frame_done_s = 1'b0;
        bit_done_s   = tick_s && (sc_r == SC_S2);
        maj_s        = maj3(samp_r[0], samp_r[1], rxs_s);
        fe_s         = stop_err_r | ~maj_s;
        brk_s        = all_zero_r & ~maj_s;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_n = ST_START;
                    start_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_n = maj_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (bc_r == DATA_LAST)) begin
                    state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_n = ST_STOP;
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done_s && (bc_r == STOP_LAST)) begin
                    state_n      = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Tick divider, sample counter, bit counter and frame accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r      <= '0;
            sc_r       <= '0;
            bc_r       <= '0;
            samp_r     <= 2'b11;
            shift_r    <= '0;
            perr_r     <= 1'b0;
            stop_err_r <= 1'b0;
            all_zero_r <= 1'b1;
        end else begin
            if (start_s || tick_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (start_s) begin
                sc_r <= '0;
            end else if (tick_s && (state_r != ST_IDLE)) begin
                sc_r <= (sc_r == SC_LAST) ? '0 : sc_r + SC_W'(1);
            end
            // Counter restarts on every field change (data, parity, stop)
            if (state_n != state_r) begin
                bc_r <= '0;
            end else if (bit_done_s) begin
                bc_r <= bc_r + BC_W'(1);
            end
            if (tick_s && (sc_r == SC_S0)) samp_r[0] <= rxs_s;
            if (tick_s && (sc_r == SC_S1)) samp_r[1] <= rxs_s;
            if (bit_done_s && (state_r == ST_DATA)) begin
                shift_r <= {maj_s, shift_r[DATA_WIDTH-1:1]};
            end
            if (start_s) begin
                perr_r     <= 1'b0;
                stop_err_r <= 1'b0;
                all_zero_r <= 1'b1;
            end else if (bit_done_s) begin
                if (state_r == ST_PARITY) perr_r <= parity_fail(shift_r, maj_s);
                if ((state_r == ST_STOP) && !maj_s) stop_err_r <= 1'b1;
                if (maj_s) all_zero_r <= 1'b0;
            end
        end
    end

    // Output handshake: load on completion if the slot is free, otherwise flag overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
            rx_idle    <= 1'b1;
        end else begin
            overrun <= 1'b0;
            if (frame_done_s && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_r;
                parity_err <= perr_r;
                frame_err  <= fe_s;
                break_det  <= brk_s;
                rx_valid   <= 1'b1;
            end else begin
                if (frame_done_s) overrun <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
            rx_idle <= (state_n == ST_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three receiver configurations (8N1, 8E1, 7O2)
// fed with directed and random frames; a monitor checks every accepted frame.
module tb_uart_rx_os;
    localparam int CLKF = 1_600_000;
    localparam int BR   = 10_000;
    localparam int OS   = 16;
    localparam int BITP = 160;
    localparam int SLOW = 165;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rxd;
    logic [2:0] rdy;
    logic [7:0] a_data, b_data;
    logic [6:0] c_data;
    logic [8:0] o_data [3];
    logic [2:0] o_valid, o_pe, o_fe, o_brk, o_ovr, o_idle;

    int   total = 0;
    int   passed = 0;
    int   ovr_cnt [3];
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;

    assign o_data[0] = {1'b0, a_data};
    assign o_data[1] = {1'b0, b_data};
    assign o_data[2] = {2'b00, c_data};

    uart_rx_os #(.CLKFREQ(CLKF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .RxD(rxd[0]), .rx_data(a_data), .rx_valid(o_valid[0]), .rx_ready(rdy[0]),
        .parity_err(o_pe[0]), .frame_err(o_fe[0]), .break_det(o_brk[0]), .overrun(o_ovr[0]), .rx_idle(o_idle[0]));
    uart_rx_os #(.CLKFREQ(CLKF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .RxD(rxd[1]), .rx_data(b_data), .rx_valid(o_valid[1]), .rx_ready(rdy[1]),
        .parity_err(o_pe[1]), .frame_err(o_fe[1]), .break_det(o_brk[1]), .overrun(o_ovr[1]), .rx_idle(o_idle[1]));
    uart_rx_os #(.CLKFREQ(CLKF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_WIDTH(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .RxD(rxd[2]), .rx_data(c_data), .rx_valid(o_valid[2]), .rx_ready(rdy[2]),
        .parity_err(o_pe[2]), .frame_err(o_fe[2]), .break_det(o_brk[2]), .overrun(o_ovr[2]), .rx_idle(o_idle[2]));

    function automatic int cfg_dw(input int id);
        case (id)
            2:       cfg_dw = 7;
            default: cfg_dw = 8;
        endcase
    endfunction

    function automatic int cfg_par(input int id);
        case (id)
            1:       cfg_par = 2;
            2:       cfg_par = 1;
            default: cfg_par = 0;
        endcase
    endfunction

    function automatic int cfg_ns(input int id);
        case (id)
            2:       cfg_ns = 2;
            default: cfg_ns = 1;
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       qsize = qa.size();
            1:       qsize = qb.size();
            default: qsize = qc.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int id);
        case (id)
            0:       qpop = qa.pop_front();
            1:       qpop = qb.pop_front();
            default: qpop = qc.pop_front();
        endcase
    endfunction

    task automatic qpush(input int id, input exp_t e);
        case (id)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds a frame from the line rules, queues the expected result, then drives it.
    task automatic send_frame(input int id, input logic [8:0] data, input logic par_good,
                              input logic stopval, input int period, input bit push);
        int         dw, par, ns, n, ones;
        logic [8:0] d;
        logic       pbit;
        logic [15:0] bits;
        exp_t       e;
        dw   = cfg_dw(id);
        par  = cfg_par(id);
        ns   = cfg_ns(id);
        d    = data & ((9'd1 << dw) - 9'd1);
        ones = $countones(d);
        pbit = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        if (!par_good) pbit = ~pbit;
        bits = '0;
        n    = 1;
        for (int i = 0; i < dw; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (par != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = stopval;
            n++;
        end
        e.d   = d;
        e.pe  = (par != 0) && (((ones + int'(pbit)) % 2) != ((par == 1) ? 1 : 0));
        e.fe  = ~stopval;
        e.brk = (d == 9'd0) && ((par == 0) || !pbit) && !stopval;
        if (push) qpush(id, e);
        for (int i = 0; i < n; i++) begin
            rxd[id] = bits[i];
            tick_wait(period);
        end
        rxd[id] = 1'b1;
    endtask

    task automatic measure_latency();
        int n;
        n = 0;
        while (!o_valid[0] && n < 3000) begin
            tick_wait(1);
            n++;
        end
        chk("latency_window", 32'((n >= 1520) && (n <= 1565)), 32'd1);
        tick_wait(1);
        chk("valid_one_clk_pulse", 32'(o_valid[0]), 32'd0);
    endtask

    // Scoreboard monitor: compares every accepted frame against the queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (o_valid[i] && rdy[i]) begin
                    if (qsize(i) == 0) begin
                        total++;
                        $display("FAIL unexpected_frame dut%0d: got data 0x%0h, required no frame", i, o_data[i]);
                    end else begin
                        exp_t e;
                        e = qpop(i);
                        chk($sformatf("data_dut%0d", i), 32'(o_data[i]), 32'(e.d));
                        chk($sformatf("parity_err_dut%0d", i), 32'(o_pe[i]), 32'(e.pe));
                        chk($sformatf("frame_err_dut%0d", i), 32'(o_fe[i]), 32'(e.fe));
                        chk($sformatf("break_det_dut%0d", i), 32'(o_brk[i]), 32'(e.brk));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_ovr[i]) ovr_cnt[i]++;
        end
    end

    initial begin
        int ovr0;
        for (int i = 0; i < 3; i++) ovr_cnt[i] = 0;
        reset = 1'b1;
        rxd   = 3'b111;
        rdy   = 3'b111;
        tick_wait(5);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_idle", 32'(o_idle), 32'h7);
        chk("reset_flags", 32'({o_pe, o_fe, o_brk, o_ovr}), 32'd0);
        chk("reset_data_a", 32'(a_data), 32'd0);
        reset = 1'b0;
        tick_wait(20);

        // 8N1 basic frame with latency and pulse width
        fork
            send_frame(0, 9'h0A5, 1'b1, 1'b1, BITP, 1'b1);
            measure_latency();
        join
        tick_wait(BITP);
        send_frame(0, 9'h03C, 1'b1, 1'b0, BITP, 1'b1);
        tick_wait(BITP);
        for (int k = 0; k < 4; k++) begin
            send_frame(0, 9'($urandom_range(255, 0)), 1'b1, 1'($urandom_range(3, 0) != 0), BITP, 1'b1);
            tick_wait(BITP);
        end

        // Break: twelve bit times low yields exactly one frame
        qpush(0, '{d: 9'd0, pe: 1'b0, fe: 1'b1, brk: 1'b1});
        rxd[0] = 1'b0;
        tick_wait(12 * BITP);
        rxd[0] = 1'b1;
        tick_wait(2 * BITP);

        // Glitch: short low pulse is rejected as a false start
        rxd[0] = 1'b0;
        tick_wait(40);
        chk("glitch_busy", 32'(o_idle[0]), 32'd0);
        rxd[0] = 1'b1;
        tick_wait(300);
        chk("glitch_idle", 32'(o_idle[0]), 32'd1);

        // Backpressure: second frame is dropped with one overrun pulse
        rdy[0] = 1'b0;
        ovr0   = ovr_cnt[0];
        send_frame(0, 9'h011, 1'b1, 1'b1, BITP, 1'b1);
        tick_wait(BITP);
        send_frame(0, 9'h022, 1'b1, 1'b1, BITP, 1'b0);
        tick_wait(BITP);
        chk("bp_valid_held", 32'(o_valid[0]), 32'd1);
        chk("bp_data_held", 32'(a_data), 32'h11);
        chk("bp_overrun_once", 32'(ovr_cnt[0] - ovr0), 32'd1);
        rdy[0] = 1'b1;
        tick_wait(2);
        chk("bp_valid_cleared", 32'(o_valid[0]), 32'd0);

        // Even parity
        send_frame(1, 9'h007, 1'b1, 1'b1, BITP, 1'b1);
        tick_wait(BITP);
        send_frame(1, 9'h007, 1'b0, 1'b1, BITP, 1'b1);
        tick_wait(BITP);
        for (int k = 0; k < 3; k++) begin
            send_frame(1, 9'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), 1'b1, BITP, 1'b1);
            tick_wait(BITP);
        end

        // 7O2 with a slow sender, then reset mid-frame
        send_frame(2, 9'h055, 1'b1, 1'b1, SLOW, 1'b1);
        tick_wait(2 * BITP);
        send_frame(2, 9'($urandom_range(127, 0)), 1'($urandom_range(1, 0)), 1'b1, SLOW, 1'b1);
        tick_wait(2 * BITP);
        rxd[2] = 1'b0;
        tick_wait(4 * BITP);
        chk("midframe_busy", 32'(o_idle[2]), 32'd0);
        reset = 1'b1;
        tick_wait(3);
        chk("midreset_valid_c", 32'(o_valid[2]), 32'd0);
        chk("midreset_data_c", 32'(c_data), 32'd0);
        chk("midreset_idle_c", 32'(o_idle[2]), 32'd1);
        chk("midreset_flags_c", 32'({o_pe[2], o_fe[2], o_brk[2], o_ovr[2]}), 32'd0);
        chk("midreset_data_a", 32'(a_data), 32'd0);
        rxd[2] = 1'b1;
        reset  = 1'b0;
        tick_wait(2 * BITP);
        send_frame(2, 9'h05A, 1'b1, 1'b1, BITP, 1'b1);
        tick_wait(2 * BITP);

        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        chk("queue_c_drained", 32'(qc.size()), 32'd0);
        chk("no_overrun_b", 32'(ovr_cnt[1]), 32'd0);
        chk("no_overrun_c", 32'(ovr_cnt[2]), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
